// File: rtl/min_sec_counter.sv
// Minute/second time base: prescaled 1 Hz tick driving 0..59 second and minute counters with run/stop and clear.
// Optional display hold with snapshot registers when LAP_HOLD_EN is defined.
module min_sec_counter #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter bit START_RUN = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run_btn,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic [5:0] o_min,
    output logic [6:0] o_sec,
    output logic       o_running,
    output logic       o_tick,
    output logic       o_wrap,
    output logic       o_hold
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0] r_presc;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic          r_running;
    logic          r_tick;
    logic          r_wrap;

    logic          w_tick_edge;
    logic          w_sec_last;
    logic          w_min_last;
    logic [5:0]    w_sec_next;
    logic [5:0]    w_min_next;

    // Clear suppresses the tick; the run state used here is the pre-toggle value.
    always_comb begin
        w_tick_edge = r_running && (r_presc == PRESC_MAX) && !i_clear;
        w_sec_last  = (r_sec == 6'd59);
        w_min_last  = (r_min == 6'd59);
        w_sec_next  = r_sec;
        w_min_next  = r_min;
        if (i_clear) begin
            w_sec_next = 6'd0;
            w_min_next = 6'd0;
        end else if (w_tick_edge) begin
            if (w_sec_last) begin
                w_sec_next = 6'd0;
                w_min_next = w_min_last ? 6'd0 : r_min + 6'd1;
            end else begin
                w_sec_next = r_sec + 6'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc   <= '0;
            r_sec     <= 6'd0;
            r_min     <= 6'd0;
            r_running <= START_RUN;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_sec     <= w_sec_next;
            r_min     <= w_min_next;
            r_running <= r_running ^ i_run_btn;
            r_tick    <= w_tick_edge;
            r_wrap    <= w_tick_edge && w_sec_last && w_min_last;
            if (i_clear)
                r_presc <= '0;
            else if (r_running)
                r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
        end
    end

    assign o_running = r_running;
    assign o_tick    = r_tick;
    assign o_wrap    = r_wrap;

`ifdef LAP_HOLD_EN
    logic       r_hold;
    logic [5:0] r_snap_min;
    logic [5:0] r_snap_sec;

    // Snapshot takes the post-update time so a coincident tick is included.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold     <= 1'b0;
            r_snap_min <= 6'd0;
            r_snap_sec <= 6'd0;
        end else if (i_clear) begin
            r_hold <= 1'b0;
        end else if (i_lap) begin
            r_hold <= !r_hold;
            if (!r_hold) begin
                r_snap_min <= w_min_next;
                r_snap_sec <= w_sec_next;
            end
        end
    end

    assign o_min  = r_hold ? r_snap_min : r_min;
    assign o_sec  = {1'b0, (r_hold ? r_snap_sec : r_sec)};
    assign o_hold = r_hold;
`else
    logic w_unused_lap;
    assign w_unused_lap = i_lap;
    assign o_min  = r_min;
    assign o_sec  = {1'b0, r_sec};
    assign o_hold = 1'b0;
`endif

endmodule

// File: doc/min_sec_counter.md
Name: min_sec_counter

Overview:
- Upstream stage of the minute/second FND path: generates the running minute and second values that the digit-splitting stage turns into four BCD digits.
- Contains a clock prescaler that produces a 1 Hz tick, a 0..59 second counter and a 0..59 minute counter.
- Adds run/stop (on/off) toggle control and a synchronous clear.
- Outputs are registered binary values with the widths the digit splitter expects: minutes 6 bits, seconds 7 bits.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ, and DIV must be at least 2.
- START_RUN, 0, run state after reset: 1 means counting, 0 means stopped.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_run_btn  input  1  single-cycle pulse, already debounced upstream; toggles run/stop.
- i_clear  input  1  single-cycle pulse; zeroes time and prescaler.
- i_lap  input  1  single-cycle pulse; toggles display hold. Used only with the optional feature.
- o_min  output  6  minutes, 0..59.
- o_sec  output  7  seconds, 0..59; bit 6 is always 0.
- o_running  output  1  1 while counting.
- o_tick  output  1  one-cycle pulse coincident with each time update.
- o_wrap  output  1  one-cycle pulse when 59:59 rolls over to 00:00.
- o_hold  output  1  display hold active; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - prescaler = 0, sec = 0, min = 0.
  - o_running = START_RUN.
  - o_tick, o_wrap and o_hold = 0.
- Prescaler:
  - Counts 0..DIV-1 only while running.
  - While stopped it holds its value, so resuming continues the partial second.
- Tick edge: the clock edge where running == 1 and prescaler == DIV-1. On that edge:
  - prescaler <= 0.
  - o_tick <= 1 for exactly one cycle, so it is high in the same cycle the new time is visible.
  - sec increments. If sec was 59: sec <= 0 and min increments.
  - If min was 59 and sec was 59: min <= 0, sec <= 0, and o_wrap <= 1 for one cycle.
- Run toggle: i_run_btn inverts o_running on the next edge.
  - A tick edge in the same cycle still completes, because the condition uses the pre-toggle state.
- Clear: i_clear sets sec, min and prescaler to 0 on the next edge.
  - Clear wins over a simultaneous tick: no tick or wrap pulse is emitted.
  - The run state is unchanged by clear.
  - i_run_btn applied together with i_clear: both take effect.
- Update rate: in continuous run, updates occur every DIV cycles exactly, with no drift.
- Outputs: all outputs are registered; there are no combinational paths from input to output.
- Counter range: sec and min never leave 0..59.

Optional Feature:
- Macro: LAP_HOLD_EN.
- Defined:
  - i_lap toggles o_hold.
  - On the edge that sets o_hold, the current sec/min (including any simultaneous tick update) is captured into snapshot registers.
  - While o_hold = 1, o_min/o_sec show the snapshot and the internal counters keep running.
  - Releasing the hold shows live values again on the next cycle.
  - i_clear also forces o_hold <= 0.
  - o_tick and o_wrap always reflect the internal counters.
- Undefined:
  - i_lap is ignored, o_hold is tied 0, no snapshot registers are built.
  - o_min/o_sec always show live values.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10):
- Reset with START_RUN=0, run 50 cycles -> o_min=0, o_sec=0, o_running=0, o_tick never asserted.
- Pulse i_run_btn, run 30 cycles -> o_tick pulses at cycles 10, 20 and 30 after the toggle; o_sec goes 1, 2, 3; o_running=1.
- Preload by running 3599 ticks -> o_min=59, o_sec=59. Next tick -> 00:00, with o_tick and o_wrap both high for one cycle.
- Stop at prescaler=6, wait 100 cycles, restart -> next tick arrives 4 cycles after restart; o_sec unchanged while stopped.
- Assert i_clear in the same cycle as a tick edge at 00:07 -> 00:00, o_tick stays 0, o_running stays 1; the next tick comes 10 cycles later.
- With LAP_HOLD_EN defined: at 00:05, pulse i_lap, run 30 cycles -> o_sec stays 5 with o_hold=1. Pulse i_lap again -> o_sec=8 on the next cycle. Assert i_clear while held -> o_hold=0, 00:00.
